// File: rtl/hsync_lock_pkg.sv
// Shared video timing and sync-lock constants; the generator uses the same line
// timing so both ends agree on where a line starts.
package hsync_lock_pkg;

  typedef logic [8:0] tick_t;

  localparam tick_t      HPERIOD      = 9'd448;
  localparam tick_t      HCOUNT_MAX   = HPERIOD - 9'd1;
  localparam tick_t      HBLNK_END    = 9'd88;
  localparam tick_t      RISE_POS     = 9'd12;
  localparam tick_t      PER_TOL      = 9'd2;
  localparam tick_t      CNT_MAX      = 9'd511;
  localparam logic [2:0] LOCK_LINES   = 3'd4;
  localparam logic [1:0] UNLOCK_LINES = 2'd2;

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_TRACK   = 2'd2;

  // Distance to the nominal period is taken in 10 bits so neither side can wrap.
  function automatic logic within_tol(input tick_t cnt);
    logic [9:0] a;
    logic [9:0] p;
    logic [9:0] diff;
    a    = {1'b0, cnt};
    p    = {1'b0, HPERIOD};
    diff = (a >= p) ? (a - p) : (p - a);
    return diff <= {1'b0, PER_TOL};
  endfunction

endpackage

// File: rtl/hsync_lock_if.sv
// Sync-path bundle between the timing source (master) and the lock receiver (slave).
// Strobes are plain level signals; cend/pre_cend are one-clk pulses, no handshake.
interface hsync_lock_if;
  import hsync_lock_pkg::*;

  logic  cend;
  logic  pre_cend;
  logic  hsync_in;
  logic  locked;
  tick_t hcount_rec;
  tick_t period;
  tick_t width;
  logic  line_start_rec;
  logic  sync_err;

  modport master (
    output cend, pre_cend, hsync_in,
    input  locked, hcount_rec, period, width, line_start_rec, sync_err
  );

  modport slave (
    input  cend, pre_cend, hsync_in,
    output locked, hcount_rec, period, width, line_start_rec, sync_err
  );

endinterface

// File: rtl/hsync_lock_meas.sv
// hsync front end: synchronizer, cend-rate edge detect, period/width counters.
// rise_o is qualified by cend; to_o is the raw saturation flag of the period counter.
module hsync_meas
  import hsync_lock_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  cend_i,
  input  logic  hsync_i,
  input  logic  capture_i,
  output logic  rise_o,
  output logic  to_o,
  output tick_t meas_cnt_o,
  output tick_t period_o,
  output tick_t width_o
);

  logic  sync1_q, sync2_q;
  logic  hs_prev_q, hs_prev_d;
  tick_t meas_cnt_q, meas_cnt_d;
  tick_t wcnt_q, wcnt_d;
  tick_t period_q, period_d;
  tick_t width_q, width_d;
  logic  rise, fall;

  always_comb begin
    rise       = cend_i & sync2_q & ~hs_prev_q;
    fall       = cend_i & ~sync2_q & hs_prev_q;
    hs_prev_d  = cend_i ? sync2_q : hs_prev_q;
    meas_cnt_d = meas_cnt_q;
    wcnt_d     = wcnt_q;
    if (cend_i) begin
      if (rise)                       meas_cnt_d = 9'd1;
      else if (meas_cnt_q != CNT_MAX) meas_cnt_d = meas_cnt_q + 9'd1;
      if (rise)                               wcnt_d = 9'd1;
      else if (sync2_q && wcnt_q != CNT_MAX)  wcnt_d = wcnt_q + 9'd1;
    end
    // The first edge after SEARCH only arms the counter; its count is meaningless.
    period_d = (rise && capture_i) ? meas_cnt_q : period_q;
    width_d  = fall ? wcnt_q : width_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      hs_prev_q  <= 1'b0;
      meas_cnt_q <= '0;
      wcnt_q     <= '0;
      period_q   <= '0;
      width_q    <= '0;
    end else begin
      sync1_q    <= hsync_i;
      sync2_q    <= sync1_q;
      hs_prev_q  <= hs_prev_d;
      meas_cnt_q <= meas_cnt_d;
      wcnt_q     <= wcnt_d;
      period_q   <= period_d;
      width_q    <= width_d;
    end
  end

  assign rise_o     = rise;
  assign to_o       = (meas_cnt_q == CNT_MAX);
  assign meas_cnt_o = meas_cnt_q;
  assign period_o   = period_q;
  assign width_o    = width_q;

endmodule

// File: rtl/hsync_lock.sv
// Horizontal sync receiver: qualifies lock on the incoming hsync train and
// free-runs a horizontal counter phased to it, with a recreated line_start.
module hsync_lock
  import hsync_lock_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  hsync_lock_if.slave  bus,
  output logic [1:0]   dbg_state_o
);

  logic       rise, to, good;
  tick_t      meas_cnt;
  logic [1:0] state_q, state_d;
  logic [2:0] good_cnt_q, good_cnt_d;
  logic [1:0] bad_cnt_q, bad_cnt_d;
  logic       locked_q, locked_d;
  logic       sync_err_q, sync_err_d;
  logic       line_start_q, line_start_d;
  tick_t      hcount_q, hcount_d;

  hsync_meas u_meas (
    .clk        (clk),
    .rst_n      (rst_n),
    .cend_i     (bus.cend),
    .hsync_i    (bus.hsync_in),
    .capture_i  (state_q != ST_SEARCH),
    .rise_o     (rise),
    .to_o       (to),
    .meas_cnt_o (meas_cnt),
    .period_o   (bus.period),
    .width_o    (bus.width)
  );

  always_comb begin
    good         = rise && within_tol(meas_cnt);
    state_d      = state_q;
    good_cnt_d   = good_cnt_q;
    bad_cnt_d    = bad_cnt_q;
    locked_d     = locked_q;
    sync_err_d   = 1'b0;
    hcount_d     = hcount_q;
    line_start_d = bus.pre_cend && locked_q && (hcount_q == HBLNK_END);
    if (bus.cend) begin
      case (state_q)
        ST_SEARCH: begin
          if (rise) begin
            state_d    = ST_MEASURE;
            good_cnt_d = '0;
          end
        end
        ST_MEASURE: begin
          if (good) begin
            if (good_cnt_q + 3'd1 == LOCK_LINES) begin
              state_d    = ST_TRACK;
              locked_d   = 1'b1;
              good_cnt_d = '0;
              bad_cnt_d  = '0;
            end else begin
              good_cnt_d = good_cnt_q + 3'd1;
            end
          end else if (rise) begin
            good_cnt_d = '0;
          end else if (to) begin
            state_d = ST_SEARCH;
          end
        end
        ST_TRACK: begin
          // A rise that coincides with timeout is judged as a rise.
          if (good) begin
            bad_cnt_d = '0;
          end else if (rise || to) begin
            sync_err_d = 1'b1;
            if (bad_cnt_q + 2'd1 == UNLOCK_LINES) begin
              state_d   = ST_SEARCH;
              locked_d  = 1'b0;
              bad_cnt_d = '0;
            end else begin
              bad_cnt_d = bad_cnt_q + 2'd1;
            end
          end
        end
        default: state_d = ST_SEARCH;
      endcase
      // Bad rises never re-phase the counter; only a good edge does.
      if (good && state_q != ST_SEARCH) hcount_d = RISE_POS;
      else if (state_q == ST_TRACK)     hcount_d = (hcount_q == HCOUNT_MAX) ? 9'd0 : hcount_q + 9'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_SEARCH;
      good_cnt_q   <= '0;
      bad_cnt_q    <= '0;
      locked_q     <= 1'b0;
      sync_err_q   <= 1'b0;
      line_start_q <= 1'b0;
      hcount_q     <= '0;
    end else begin
      state_q      <= state_d;
      good_cnt_q   <= good_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
      locked_q     <= locked_d;
      sync_err_q   <= sync_err_d;
      line_start_q <= line_start_d;
      hcount_q     <= hcount_d;
    end
  end

  assign bus.locked         = locked_q;
  assign bus.sync_err       = sync_err_q;
  assign bus.line_start_rec = line_start_q;
  assign bus.hcount_rec     = hcount_q;
  assign dbg_state_o        = state_q;

endmodule
